// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory controller: FSM states, width codes,
// IO address select, busy bit positions and the width-to-length helper.
package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_IF_RD  = 3'd1,
        ST_MEM_RD = 3'd2,
        ST_MEM_WR = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [1:0] WIDTH_BYTE = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b01;
    localparam logic [1:0] WIDTH_WORD = 2'b10;

    // Address bits [17:16] equal to this select the IO window.
    localparam logic [1:0] IO_ADDR_SEL = 2'b11;

    localparam int unsigned BUSY_IF_BIT  = 0;
    localparam int unsigned BUSY_MEM_BIT = 1;

    // Byte counter must reach 4 (one past the last byte of a word read).
    localparam int unsigned CNT_W = 3;

    // Width code 2'b11 is treated as a word.
    function automatic logic [CNT_W-1:0] width_to_len(input logic [1:0] width);
        case (width)
            WIDTH_BYTE: return CNT_W'(1);
            WIDTH_HALF: return CNT_W'(2);
            default:    return CNT_W'(4);
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_ram_byte_seq.sv
// Byte sequencer: counts bytes of the current transfer and produces the
// current RAM byte address (base + count, modulo 2^32) plus range flags.
module ram_byte_seq
    import mem_ctrl_pkg::*;
(
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             clr_in,
    input  logic             inc_in,
    input  logic [31:0]      base_addr_in,
    input  logic [CNT_W-1:0] len_in,
    output logic [CNT_W-1:0] cnt_out,
    output logic [31:0]      cur_addr_out,
    output logic             addr_valid_out,
    output logic             last_out
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: clear has priority over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_in) begin
            cnt_d = '0;
        end else if (inc_in) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_out        = cnt_q;
    assign cur_addr_out   = base_addr_in + 32'(cnt_q);
    assign addr_valid_out = (cnt_q < len_in);
    assign last_out       = (cnt_q == len_in - 1'b1);

endmodule

// File: rtl/mem_ctrl.sv
// Memory controller: arbitrates instruction fetch and load/store onto a
// byte-wide RAM. Optional macro MEM_CTRL_IO_STALL_EN stalls stores into
// the IO window while the external IO FIFO is full.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        if_req_in,
    input  logic [31:0] if_addr_in,
    input  logic        branch_flag_in,
    input  logic        mem_req_in,
    input  logic        mem_we_in,
    input  logic [31:0] mem_addr_in,
    input  logic [1:0]  mem_width_in,
    input  logic [31:0] mem_wdata_in,
    input  logic        io_buffer_full_in,
    input  logic [7:0]  ram_din_in,
    output logic [31:0] if_inst_out,
    output logic        if_done_out,
    output logic [31:0] mem_rdata_out,
    output logic        mem_done_out,
    output logic [1:0]  busy_out,
    output logic [31:0] ram_a_out,
    output logic [7:0]  ram_dout_out,
    output logic        ram_wr_out
);

    state_t           state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      data_q, data_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             is_mem_q, is_mem_d;

    logic             seq_clr, seq_inc, seq_valid, seq_last, io_stall;
    logic [CNT_W-1:0] seq_cnt;
    logic [31:0]      seq_addr;
    logic [1:0]       cap_idx, wr_idx;

    ram_byte_seq u_seq (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .clr_in         (seq_clr),
        .inc_in         (seq_inc),
        .base_addr_in   (addr_q),
        .len_in         (len_q),
        .cnt_out        (seq_cnt),
        .cur_addr_out   (seq_addr),
        .addr_valid_out (seq_valid),
        .last_out       (seq_last)
    );

    // RAM data lags its address by one cycle, so the byte arriving now
    // belongs to the previous count.
    assign cap_idx = 2'(seq_cnt - 1'b1);
    assign wr_idx  = seq_cnt[1:0];

`ifdef MEM_CTRL_IO_STALL_EN
    assign io_stall = (state_q == ST_MEM_WR) && (seq_addr[17:16] == IO_ADDR_SEL) && io_buffer_full_in;
`else
    logic unused_io_full;
    assign unused_io_full = io_buffer_full_in;
    assign io_stall       = 1'b0;
`endif

    // Next-state, request latching, byte capture and sequencer control.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        data_d   = data_q;
        len_d    = len_q;
        is_mem_d = is_mem_q;
        seq_clr  = 1'b0;
        seq_inc  = 1'b0;
        if (rdy_in) begin
            case (state_q)
                ST_IDLE: begin
                    seq_clr = 1'b1;
                    if (mem_req_in) begin
                        addr_d   = mem_addr_in;
                        wdata_d  = mem_wdata_in;
                        len_d    = width_to_len(mem_width_in);
                        data_d   = '0;
                        is_mem_d = 1'b1;
                        state_d  = mem_we_in ? ST_MEM_WR : ST_MEM_RD;
                    end else if (if_req_in) begin
                        addr_d   = if_addr_in;
                        wdata_d  = '0;
                        len_d    = CNT_W'(4);
                        data_d   = '0;
                        is_mem_d = 1'b0;
                        state_d  = ST_IF_RD;
                    end
                end
                ST_IF_RD, ST_MEM_RD: begin
                    if (state_q == ST_IF_RD && branch_flag_in) begin
                        seq_clr = 1'b1;
                        data_d  = '0;
                        state_d = ST_IDLE;
                    end else begin
                        if (seq_cnt != '0) begin
                            data_d[{cap_idx, 3'b000} +: 8] = ram_din_in;
                        end
                        if (seq_valid) begin
                            seq_inc = 1'b1;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_MEM_WR: begin
                    if (!io_stall) begin
                        seq_inc = 1'b1;
                        if (seq_last) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    seq_clr = 1'b1;
                    state_d = ST_IDLE;
                end
                default: begin
                    seq_clr = 1'b1;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decoded from the current state; idle values are all zero.
    always_comb begin
        ram_a_out     = '0;
        ram_dout_out  = '0;
        ram_wr_out    = 1'b0;
        busy_out      = '0;
        if_done_out   = 1'b0;
        mem_done_out  = 1'b0;
        if_inst_out   = '0;
        mem_rdata_out = '0;
        case (state_q)
            ST_IF_RD: begin
                busy_out[BUSY_IF_BIT] = 1'b1;
                if (seq_valid) begin
                    ram_a_out = seq_addr;
                end
            end
            ST_MEM_RD: begin
                busy_out[BUSY_MEM_BIT] = 1'b1;
                if (seq_valid) begin
                    ram_a_out = seq_addr;
                end
            end
            ST_MEM_WR: begin
                busy_out[BUSY_MEM_BIT] = 1'b1;
                ram_a_out    = seq_addr;
                ram_dout_out = wdata_q[{wr_idx, 3'b000} +: 8];
                ram_wr_out   = rdy_in && !io_stall;
            end
            ST_DONE: begin
                if (is_mem_q) begin
                    mem_done_out  = 1'b1;
                    mem_rdata_out = data_q;
                end else begin
                    if_done_out = 1'b1;
                    if_inst_out = data_q;
                end
            end
            default: begin
            end
        endcase
    end

    // State and latched-request registers.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            data_q   <= '0;
            len_q    <= '0;
            is_mem_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            data_q   <= data_d;
            len_q    <= len_d;
            is_mem_q <= is_mem_d;
        end
    end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 clk_in  input  1  system clock; all state updates on rising edge.
REQ-002 rst_in  input  1  asynchronous, active-low reset.
REQ-003 rdy_in  input  1  global ready; low freezes all state.
REQ-004 if_req_in  input  1  instruction-fetch request, held by requester until if_done_out.
REQ-005 if_addr_in  input  32  fetch byte address.
REQ-006 branch_flag_in  input  1  pipeline flush; aborts an in-flight fetch.
REQ-007 mem_req_in  input  1  load/store request, held until mem_done_out.
REQ-008 mem_we_in  input  1  1 = store, 0 = load.
REQ-009 mem_addr_in  input  32  load/store byte address.
REQ-010 mem_width_in  input  2  00 byte, 01 half, 10 word; 11 treated as word.
REQ-011 mem_wdata_in  input  32  store data, little-endian, low bytes used.
REQ-012 io_buffer_full_in  input  1  external IO FIFO full.
REQ-013 ram_din_in  input  8  RAM read byte, valid the cycle after its address.
REQ-014 if_inst_out  output  32  fetched word, valid while if_done_out is high.
REQ-015 if_done_out  output  1  one-cycle fetch-complete pulse.
REQ-016 mem_rdata_out  output  32  load data, zero-extended, valid while mem_done_out is high.
REQ-017 mem_done_out  output  1  one-cycle load/store-complete pulse.
REQ-018 busy_out  output  2  bit0 = serving IF; bit1 = serving MEM; never both set.
REQ-019 ram_a_out  output  32  RAM byte address.
REQ-020 ram_dout_out  output  8  RAM write byte.
REQ-021 ram_wr_out  output  1  RAM write strobe.

Function
REQ-022 FSM states: IDLE, IF_RD, MEM_RD, MEM_WR, DONE.
REQ-023 In IDLE with mem_req_in high: latch address, width and data, then go to MEM_RD or MEM_WR; MEM has priority over a simultaneous if_req_in.
REQ-024 In IDLE with only if_req_in high: latch address, go to IF_RD with length 4.
REQ-025 Read of n bytes: cycles 1..n after the accepting edge drive ram_a_out = addr+k-1, ram_wr_out=0; byte k is captured from ram_din_in one cycle after its address; done pulses in cycle n+2.
REQ-026 Write of n bytes: cycles 1..n drive ram_wr_out=1, ram_a_out=addr+k-1, ram_dout_out=wdata byte k-1; mem_done_out pulses in cycle n+1.
REQ-027 DONE lasts exactly one cycle, then returns to IDLE; a new request is accepted no earlier than the cycle after DONE.
REQ-028 busy_out bit is high from the cycle after acceptance through the cycle before the done pulse.
REQ-029 branch_flag_in high in IF_RD: next state IDLE, no if_done_out, busy_out[0] cleared, partial data discarded; MEM transfers are never aborted.
REQ-030 rdy_in low: state, counter and outputs hold; ram_wr_out forced 0.
REQ-031 Address arithmetic is 32-bit with modulo-2^32 wrap; a byte sequence may cross any boundary.
REQ-032 Outside active phases: ram_wr_out=0, ram_a_out=0, ram_dout_out=0, done outputs 0.

Reset
REQ-033 On rst_in low: state IDLE, byte counter 0, all outputs 0, latched data 0; a transfer in progress is dropped without a done pulse.
REQ-034 After rst_in rises, requests are accepted from the first rising edge.

Configuration
REQ-035 Macro MEM_CTRL_IO_STALL_EN defined: a write byte to an address with bits [17:16]==2'b11 while io_buffer_full_in is high is not issued (ram_wr_out=0); the counter holds until io_buffer_full_in is low.
REQ-036 Macro MEM_CTRL_IO_STALL_EN undefined: io_buffer_full_in is ignored; the port remains present.

Structure
REQ-037 The shared defines package holds the FSM state encoding, the width codes, the IO address-select constant and the busy bit indices.
REQ-038 Sub-module ram_byte_seq holds the byte counter, address increment and last-byte flag; mem_ctrl holds the FSM and data assembly.

Verification
REQ-039 if_req_in=1, addr 0x100, RAM bytes 13 00 00 00 -> ram_a_out 0x100..0x103 in cycles 1..4; if_done_out in cycle 6 with if_inst_out 0x00000013.
REQ-040 mem_req_in and if_req_in both rise together, load byte at 0x200=0xFF -> MEM served first with mem_rdata_out 0x000000FF in cycle 3; IF accepted after DONE.
REQ-041 Store word 0xAABBCCDD to 0x300 -> writes DD,CC,BB,AA to 0x300..0x303; mem_done_out in cycle 5.
REQ-042 branch_flag_in pulses in cycle 2 of a fetch -> no if_done_out; busy_out = 00 next cycle.
REQ-043 With MEM_CTRL_IO_STALL_EN, store byte to 0x30000 with io_buffer_full_in high for 3 cycles -> ram_wr_out stays low 3 cycles, then one write; done one cycle later.
REQ-044 rst_in low mid-fetch -> all outputs 0 immediately; no done pulse after release.
